// File: rtl/decode_stage.sv
// Single-cycle registered RV32/RV64 instruction decode stage with valid/ready
// handshakes; classifies format, extracts fields and builds the sign-extended immediate.
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [XLEN-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
  output logic                      out_rs1_used,
  output logic                      out_rs2_used,
  output logic                      out_rd_we,
  output logic [XLEN-1:0]           out_imm,
  output logic [2:0]                out_fmt,
  output logic                      out_illegal
);

  // Handshake: an instruction transfers on in_valid && in_ready; the held one
  // leaves on out_valid && out_ready; in_ready = !out_valid || out_ready.
  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  logic                      valid_q;
  logic [XLEN-1:0]           pc_q;
  logic [6:0]                opcode_q;
  logic [2:0]                funct3_q;
  logic [6:0]                funct7_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic                      rs1_used_q, rs2_used_q, rd_we_q;
  logic [XLEN-1:0]           imm_q;
  fmt_e                      fmt_q;
  logic                      illegal_q;

  fmt_e                      fmt_d;
  logic                      rs1_used_d, rs2_used_d, rd_we_d, illegal_d;
  logic [31:0]               imm32;
  logic [XLEN-1:0]           imm_d;
  logic                      is_fence;
  logic [6:0]                opcode, funct7;
  logic                      accept;

  assign opcode   = in_instr[6:0];
  assign funct7   = in_instr[31:25];
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fmt_d      = FMT_NONE;
    is_fence   = 1'b0;
    rs1_used_d = 1'b0;
    rs2_used_d = 1'b0;
    rd_we_d    = 1'b0;
    imm32      = 32'd0;
    if (in_instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0110011: if (funct7 == 7'b0000000 || funct7 == 7'b0100000) fmt_d = FMT_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_d = FMT_I;
        7'b0001111: begin
          fmt_d    = FMT_I;
          is_fence = 1'b1;
        end
        7'b0100011: fmt_d = FMT_S;
        7'b1100011: fmt_d = FMT_B;
        7'b0110111, 7'b0010111: fmt_d = FMT_U;
        7'b1101111: fmt_d = FMT_J;
        default: fmt_d = FMT_NONE;
      endcase
    end
    case (fmt_d)
      FMT_R: begin
        rs1_used_d = 1'b1;
        rs2_used_d = 1'b1;
        rd_we_d    = 1'b1;
      end
      FMT_I: begin
        rs1_used_d = !is_fence;
        rd_we_d    = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      FMT_S: begin
        rs1_used_d = 1'b1;
        rs2_used_d = 1'b1;
        imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      FMT_B: begin
        rs1_used_d = 1'b1;
        rs2_used_d = 1'b1;
        imm32      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      FMT_U: begin
        rd_we_d = 1'b1;
        imm32   = {in_instr[31:12], 12'd0};
      end
      FMT_J: begin
        rd_we_d = 1'b1;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: imm32 = 32'd0;
    endcase
    // Writes to x0 are architecturally discarded, so hazard logic must not see them.
    if (in_instr[11:7] == 5'd0) rd_we_d = 1'b0;
    illegal_d = (fmt_d == FMT_NONE);
  end

  assign imm_d = XLEN'($signed(imm32));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      rd_we_q    <= 1'b0;
      imm_q      <= '0;
      fmt_q      <= FMT_NONE;
      illegal_q  <= 1'b0;
    end else if (flush) begin
      // Flush kills both the held and the incoming instruction; fields keep old values.
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      pc_q       <= in_pc;
      opcode_q   <= opcode;
      funct3_q   <= in_instr[14:12];
      funct7_q   <= funct7;
      rs1_q      <= REG_ADDR_WIDTH'(in_instr[19:15]);
      rs2_q      <= REG_ADDR_WIDTH'(in_instr[24:20]);
      rd_q       <= REG_ADDR_WIDTH'(in_instr[11:7]);
      rs1_used_q <= rs1_used_d;
      rs2_used_q <= rs2_used_d;
      rd_we_q    <= rd_we_d;
      imm_q      <= imm_d;
      fmt_q      <= fmt_d;
      illegal_q  <= illegal_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_opcode   = opcode_q;
  assign out_funct3   = funct3_q;
  assign out_funct7   = funct7_q;
  assign out_rs1_addr = rs1_q;
  assign out_rs2_addr = rs2_q;
  assign out_rd_addr  = rd_q;
  assign out_rs1_used = rs1_used_q;
  assign out_rs2_used = rs2_used_q;
  assign out_rd_we    = rd_we_q;
  assign out_imm      = imm_q;
  assign out_fmt      = fmt_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset values, decode table with back-to-back
// issue, backpressure, flush and reset-while-busy.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_fmt;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr;
  logic        out_rs1_used, out_rs2_used, out_rd_we, out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-decoded vectors: instr, fmt, imm, {rs1_used,rs2_used,rd_we,illegal}, rd, rs1, rs2
  localparam int NV = 15;
  logic [31:0] v_instr [NV] = '{32'hFFF10093, 32'h00112223, 32'hFFDFF0EF, 32'h002081B3,
                                32'h402081B3, 32'h022081B3, 32'h123452B7, 32'hFE208CE3,
                                32'h0000000F, 32'h00000000, 32'h00000012, 32'h00000013,
                                32'hFFFFF397, 32'h00000073, 32'h8001A503};
  logic [2:0]  v_fmt   [NV] = '{3'd1, 3'd2, 3'd5, 3'd0, 3'd0, 3'd7, 3'd4, 3'd3,
                                3'd1, 3'd7, 3'd7, 3'd1, 3'd4, 3'd1, 3'd1};
  logic [31:0] v_imm   [NV] = '{32'hFFFFFFFF, 32'h00000004, 32'hFFFFFFFC, 32'h0,
                                32'h0, 32'h0, 32'h12345000, 32'hFFFFFFF8,
                                32'h0, 32'h0, 32'h0, 32'h0,
                                32'hFFFFF000, 32'h0, 32'hFFFFF800};
  logic [3:0]  v_flags [NV] = '{4'b1010, 4'b1100, 4'b0010, 4'b1110, 4'b1110, 4'b0001,
                                4'b0010, 4'b1100, 4'b0000, 4'b0001, 4'b0001, 4'b1000,
                                4'b0010, 4'b1000, 4'b1010};
  logic [4:0]  v_rd    [NV] = '{5'd1, 5'd4, 5'd1, 5'd3, 5'd3, 5'd3, 5'd5, 5'd25,
                                5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd10};
  logic [4:0]  v_rs1   [NV] = '{5'd2, 5'd2, 5'd31, 5'd1, 5'd1, 5'd1, 5'd8, 5'd1,
                                5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd3};
  logic [4:0]  v_rs2   [NV] = '{5'd31, 5'd1, 5'd29, 5'd2, 5'd2, 5'd2, 5'd3, 5'd2,
                                5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0};

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h0000_0040;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_fmt", out_fmt, 3'd7);
    check("rst_imm", out_imm, 0);
    check("rst_pc", out_pc, 0);
    check("rst_rd", out_rd_addr, 0);
    check("rst_in_ready", in_ready, 1);

    // Back-to-back stream with out_ready=1: one decoded output per cycle.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = v_instr[i];
      in_pc    = 32'h1000 + 32'(4 * i);
      tick();
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
      check($sformatf("v%0d_fmt", i), out_fmt, v_fmt[i]);
      check($sformatf("v%0d_imm", i), out_imm, v_imm[i]);
      check($sformatf("v%0d_flags", i),
            {out_rs1_used, out_rs2_used, out_rd_we, out_illegal}, v_flags[i]);
      check($sformatf("v%0d_rd", i), out_rd_addr, v_rd[i]);
      check($sformatf("v%0d_rs1", i), out_rs1_addr, v_rs1[i]);
      check($sformatf("v%0d_rs2", i), out_rs2_addr, v_rs2[i]);
      check($sformatf("v%0d_opcode", i), out_opcode, {25'd0, v_instr[i][6:0]});
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);

    // Backpressure: hold A for 3 cycles while B waits upstream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00112223; in_pc = 32'h2000;
    tick();
    check("bp_a_valid", out_valid, 1);
    in_instr = 32'hFFDFF0EF; in_pc = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_in_ready", c), in_ready, 0);
      tick();
      check($sformatf("bp%0d_valid", c), out_valid, 1);
      check($sformatf("bp%0d_pc", c), out_pc, 32'h2000);
      check($sformatf("bp%0d_imm", c), out_imm, 32'h4);
      check($sformatf("bp%0d_fmt", c), out_fmt, 3'd2);
      check($sformatf("bp%0d_funct3", c), out_funct3, 3'd2);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", out_valid, 1);
    check("bp_b_pc", out_pc, 32'h2004);
    check("bp_b_fmt", out_fmt, 3'd5);
    check("bp_b_imm", out_imm, 32'hFFFFFFFC);
    tick();
    check("bp_b_gone", out_valid, 0);

    // Flush in the same cycle as an incoming instruction.
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h3000; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_valid", out_valid, 0);

    // Flush a held instruction under backpressure; in_ready still follows the handshake.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h3004;
    tick();
    check("flush_held_pre", out_valid, 1);
    in_valid = 1'b1; in_instr = 32'h00000013; flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_held_valid", out_valid, 0);
    check("flush_held_pc_kept", out_pc, 32'h3004);

    // Reset while holding a valid instruction, with another one arriving.
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h4000;
    tick();
    check("rst2_pre_valid", out_valid, 1);
    rst = 1'b1; in_instr = 32'h00112223; in_pc = 32'h4004;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rst2_valid", out_valid, 0);
    check("rst2_fmt", out_fmt, 3'd7);
    check("rst2_pc", out_pc, 0);
    check("rst2_imm", out_imm, 0);
    check("rst2_fields", {out_opcode, out_funct3, out_funct7, out_rs1_addr,
                          out_rs2_addr, out_rd_addr}, 0);
    check("rst2_flags", {out_rs1_used, out_rs2_used, out_rd_we, out_illegal}, 0);
    check("rst2_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, 32, datapath width for out_imm, in_pc and out_pc; legal values are 32 and 64.
REQ-002 Parameter REG_ADDR_WIDTH, 5, register address width; the default tracks the `REG_ADDR_WIDTH define in Defines.vh.
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on the rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port flush, input, 1, kill request for the held instruction and the instruction arriving in the same cycle.
REQ-006 Port in_valid, input, 1, upstream presents an instruction.
REQ-007 Port in_ready, output, 1, stage can accept an instruction this cycle.
REQ-008 Port in_instr, input, 32, raw instruction word.
REQ-009 Port in_pc, input, XLEN, PC of in_instr.
REQ-010 Port out_valid, output, 1, decoded instruction held.
REQ-011 Port out_ready, input, 1, downstream consumes the held instruction.
REQ-012 Port out_pc, input-registered output, XLEN, PC of the held instruction.
REQ-013 Ports out_opcode (7), out_funct3 (3), out_funct7 (7), output, raw fields from bits [6:0], [14:12] and [31:25].
REQ-014 Ports out_rs1_addr, out_rs2_addr, out_rd_addr, output, REG_ADDR_WIDTH each, register addresses from bits [19:15], [24:20] and [11:7].
REQ-015 Ports out_rs1_used, out_rs2_used, out_rd_we, output, 1 each, operand and writeback usage flags for the hazard unit.
REQ-016 Port out_imm, output, XLEN, sign-extended immediate.
REQ-017 Port out_fmt, output, 3, format code: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
REQ-018 Port out_illegal, output, 1, unrecognised encoding.

Function
REQ-019 The block SHALL be a single registered pipeline stage with valid/ready handshakes on both sides and a latency of exactly 1 cycle.
REQ-020 in_ready SHALL equal (!out_valid || out_ready) and SHALL be combinational.
REQ-021 An instruction SHALL be accepted when in_valid && in_ready; its decoded fields SHALL appear on the outputs on the next cycle with out_valid=1.
REQ-022 The held instruction SHALL leave the stage when out_valid && out_ready.
REQ-023 If the held instruction leaves and a new one is accepted in the same cycle, the stage SHALL reload, giving full throughput.
REQ-024 While out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-025 Registered output fields SHALL update only on accept.
REQ-026 Format by opcode:
- 0110011 -> R
- 0010011, 0000011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 0001111 -> I, with rs1_used=0
REQ-027 Immediate, sign bit always instr[31], sign-extended to XLEN:
- I: instr[31:20]
- S: {instr[31:25], instr[11:7]}
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- U: {instr[31:12], 12'b0}
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- R and NONE: 0
REQ-028 Usage flags:
- rs1_used: R, I, S, B
- rs2_used: R, S, B
- rd_we: R, I, U, J with rd != 0
- NONE: all three flags 0
REQ-029 out_illegal=1 with out_fmt=NONE when any of the following holds:
- the opcode is not listed in REQ-026
- instr[1:0] != 2'b11
- the opcode is R and funct7 is not 0000000 or 0100000
REQ-030 An illegal instruction SHALL still be accepted and passed downstream, with out_illegal=1 and the other usage flags at 0.
REQ-031 flush=1 SHALL force out_valid=0 on the next cycle, discarding both the held instruction and any instruction accepted in the same cycle; flush has priority over accept.
REQ-032 During flush, in_ready SHALL still follow REQ-020 so that upstream drains.

Reset
REQ-033 On rst=1 at a clock edge, out_valid SHALL become 0.
REQ-034 On the same edge, every out_* data field SHALL become 0, except out_fmt which SHALL become NONE (7).
REQ-035 rst SHALL have priority over flush and over accept.
REQ-036 An instruction in flight at reset SHALL be lost.
REQ-037 in_ready SHALL be 1 on the first cycle after reset.

Verification
REQ-038 Accept 0xFFF10093 (addi x1,x2,-1) -> next cycle:
- out_valid=1, fmt=I, rd=1, rs1=2
- imm=0xFFFFFFFF
- rs1_used=1, rs2_used=0, rd_we=1
REQ-039 Accept 0x00112223 (sw x1,4(x2)) -> fmt=S, rs1=2, rs2=1, imm=0x00000004, rd_we=0.
REQ-040 Accept 0xFFDFF0EF (jal x1,-4) -> fmt=J, imm=0xFFFFFFFC, rd_we=1.
REQ-041 Back-to-back instructions with out_ready=1 -> one output per cycle.
REQ-042 Backpressure, out_ready=0 for 3 cycles -> in_ready=0 and outputs stable throughout; release -> next instruction appears one cycle later.
REQ-043 Error and control cases:
- accept 0x00000000 -> out_illegal=1, fmt=7
- flush asserted in the same cycle as in_valid=1 -> out_valid=0 next cycle
- rst asserted while out_valid=1 -> all outputs at reset values next cycle
